adc_sample_capture: RTL

//  Downstream stage of the ADC conversion controller. Captures the parallel ADC data bus
//  DB_18 during each RD_18 read strobe and tags every sample with a sequence number.

---
 rtl/adc_capture_pkg.sv | 20 ++
 rtl/adc_sample_fifo.sv | 83 ++++++++
 rtl/adc_sample_capture.sv | 108 ++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC sample capture path.
package adc_capture_pkg;

    localparam int SEQ_W          = 8;
    localparam int DATA_W_DEF     = 16;
    localparam int FIFO_AW_DEF    = 4;
    localparam int ACCESS_CYC_DEF = 3;

    // One captured sample as it travels through the FIFO: sequence tag above data.
    typedef struct packed {
        logic [SEQ_W-1:0]      seq;
        logic [DATA_W_DEF-1:0] data;
    } sample_t;

    // Sequence numbers wrap naturally at 2**SEQ_W.
    function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous FIFO with a registered show-ahead output stage.
// The output register counts as one entry, so the memory never holds more
// than DEPTH-1 words. A push into an empty FIFO lands straight in the output
// register and is visible one cycle later.
module adc_sample_fifo #(
    parameter int WIDTH = 24,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             full,
    output logic [AW:0]      level
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      mem_cnt_reg, level_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;

    logic pop_ok, push_ok, out_free, load_mem, load_direct, write_mem;

    // Handshake qualification and routing of the incoming word.
    always_comb begin
        pop_ok      = pop && out_valid_reg;
        push_ok     = push && (!full || pop_ok);
        out_free    = !out_valid_reg || pop_ok;
        load_mem    = out_free && (mem_cnt_reg != '0);
        load_direct = out_free && (mem_cnt_reg == '0) && push_ok;
        write_mem   = push_ok && !load_direct;
    end

    // Storage array write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (write_mem)
            mem[wr_ptr_reg] <= push_data;
    end

    // Pointers, counters and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_cnt_reg   <= '0;
            level_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (write_mem)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (load_mem) begin
                out_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            end else if (load_direct) begin
                out_data_reg <= push_data;
            end
            if (out_free)
                out_valid_reg <= load_mem || load_direct;
            case ({write_mem, load_mem})
                2'b10:   mem_cnt_reg <= mem_cnt_reg + 1'b1;
                2'b01:   mem_cnt_reg <= mem_cnt_reg - 1'b1;
                default: mem_cnt_reg <= mem_cnt_reg;
            endcase
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign level     = level_reg;
    assign full      = (level_reg == (AW+1)'(DEPTH));

endmodule

// File: rtl/adc_sample_capture.sv
// Captures ADC words on each rising edge of the read strobe, tags them with a
// sequence number and streams them out through a small FIFO.
module adc_sample_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int FIFO_AW       = FIFO_AW_DEF,
    parameter int ACCESS_CYC    = ACCESS_CYC_DEF,
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic              clk_100M,
    input  logic              Reset,
    input  logic              RD_18,
    input  logic [DATA_W-1:0] DB_18,
    input  logic              enable,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] m_tdata,
    output logic [SEQ_W-1:0]  m_tuser,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    output logic              short_rd
);
    localparam int                CNT_W      = $clog2(ACCESS_CYC + 1);
    localparam logic [CNT_W-1:0]  ACCESS_LIM = CNT_W'(ACCESS_CYC);

    logic                    rd_q_reg;
    logic [CNT_W-1:0]        low_cnt_reg;
    logic [DATA_W-1:0]       hold_reg;
    logic [SEQ_W-1:0]        seq_reg;
    logic                    overflow_reg, short_rd_reg;

    logic                    rise_evt, rd_ok, push, short_evt, pop, drop, fifo_full;
    logic [DATA_W-1:0]       data_fmt;
    logic [SEQ_W+DATA_W-1:0] fifo_out;

    // Offset-binary to two's complement is just an MSB flip.
    generate
        if (OFFSET_BINARY) begin : g_offset_bin
            assign data_fmt = {~hold_reg[DATA_W-1], hold_reg[DATA_W-2:0]};
        end else begin : g_pass
            assign data_fmt = hold_reg;
        end
    endgenerate

    // Strobe-end classification: a long enough low run pushes, a short one flags.
    always_comb begin
        rise_evt  = !rd_q_reg && RD_18 && enable;
        rd_ok     = (low_cnt_reg >= ACCESS_LIM);
        push      = rise_evt && rd_ok;
        short_evt = rise_evt && !rd_ok;
        pop       = m_tvalid && m_tready;
        drop      = push && fifo_full && !pop;
    end

    // Strobe tracking, data hold, sequence counter and sticky flags.
    always_ff @(posedge clk_100M or negedge Reset) begin
        if (!Reset) begin
            rd_q_reg     <= 1'b1;
            low_cnt_reg  <= '0;
            hold_reg     <= '0;
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
            short_rd_reg <= 1'b0;
        end else begin
            rd_q_reg <= RD_18;
            if (RD_18) begin
                low_cnt_reg <= '0;
            end else begin
                hold_reg <= DB_18;
                if (low_cnt_reg < ACCESS_LIM)
                    low_cnt_reg <= low_cnt_reg + 1'b1;
            end
            if (push)
                seq_reg <= seq_inc(seq_reg);
            if (drop)
                overflow_reg <= 1'b1;
            else if (clr_flags)
                overflow_reg <= 1'b0;
            if (short_evt)
                short_rd_reg <= 1'b1;
            else if (clr_flags)
                short_rd_reg <= 1'b0;
        end
    end

    adc_sample_fifo #(
        .WIDTH (SEQ_W + DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk_100M),
        .rst_n     (Reset),
        .push      (push),
        .push_data ({seq_reg, data_fmt}),
        .pop       (m_tready),
        .out_data  (fifo_out),
        .out_valid (m_tvalid),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign m_tuser  = fifo_out[SEQ_W+DATA_W-1:DATA_W];
    assign m_tdata  = fifo_out[DATA_W-1:0];
    assign overflow = overflow_reg;
    assign short_rd = short_rd_reg;

endmodule
